// File: rtl/iommu_ddtc_multi.sv
// Device-directory translation cache: fully associative, DEPTH entries keyed by
// device_id, lowest-free fill and round-robin replacement once full, with
// single-entry and global invalidation plus saturating hit/miss statistics.
module iommu_ddtc_multi #(
  parameter int DEPTH           = 8,
  parameter int DEVICE_ID_WIDTH = 24,
  parameter int MSI_TRANSLATION = 0,
  localparam int DC_W  = (MSI_TRANSLATION != 0) ? 512 : 256,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int OCC_W = IDX_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lu_valid_i,
  input  logic [DEVICE_ID_WIDTH-1:0] lu_did_i,
  output logic                       lu_hit_o,
  output logic                       lu_miss_o,
  output logic [DC_W-1:0]            lu_dc_o,
  input  logic                       up_valid_i,
  input  logic [DEVICE_ID_WIDTH-1:0] up_did_i,
  input  logic [DC_W-1:0]            up_dc_i,
  input  logic                       inv_valid_i,
  input  logic                       inv_all_i,
  input  logic [DEVICE_ID_WIDTH-1:0] inv_did_i,
  output logic [OCC_W-1:0]           occupancy_o,
  output logic [31:0]                hit_cnt_o,
  output logic [31:0]                miss_cnt_o
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEVICE_ID_WIDTH-1:0] tag_q [DEPTH];
  logic [DC_W-1:0]            data_q [DEPTH];
  logic [IDX_W-1:0]           victim_q, victim_d;
  logic                       hit_q, hit_d;
  logic                       miss_q, miss_d;
  logic [DC_W-1:0]            dc_q, dc_d;
  logic [31:0]                hitCnt_q, hitCnt_d;
  logic [31:0]                missCnt_q, missCnt_d;

  logic                       luFound;
  logic [IDX_W-1:0]           luIdx;
  logic                       luKill;
  logic                       upEn;
  logic                       upMatch;
  logic [IDX_W-1:0]           upMatchIdx;
  logic                       freeFound;
  logic [IDX_W-1:0]           freeIdx;
  logic [IDX_W-1:0]           upIdx;
  logic [OCC_W-1:0]           occCount;

  // Lookup against pre-edge contents; a same-cycle invalidation of the looked-up did wins
  always_comb begin
    luFound = 1'b0;
    luIdx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == lu_did_i)) begin
        luFound = 1'b1;
        luIdx   = IDX_W'(i);
      end
    end
    luKill    = inv_valid_i && (inv_all_i || (inv_did_i == lu_did_i));
    hit_d     = lu_valid_i && luFound && !luKill;
    miss_d    = lu_valid_i && !(luFound && !luKill);
    dc_d      = hit_d ? data_q[luIdx] : '0;
    hitCnt_d  = (hit_d && (hitCnt_q != '1)) ? hitCnt_q + 32'd1 : hitCnt_q;
    missCnt_d = (miss_d && (missCnt_q != '1)) ? missCnt_q + 32'd1 : missCnt_q;
  end

  // Pick the fill slot: existing entry for this did, else lowest free, else victim
  always_comb begin
    upMatch    = 1'b0;
    upMatchIdx = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == up_did_i)) begin
        upMatch    = 1'b1;
        upMatchIdx = IDX_W'(i);
      end
      if (!valid_q[i] && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
    upEn  = up_valid_i && up_dc_i[0];
    upIdx = upMatch ? upMatchIdx : (freeFound ? freeIdx : victim_q);
  end

  // Next valid bits and victim pointer: update first, invalidation applied on top
  always_comb begin
    valid_d  = valid_q;
    victim_d = victim_q;
    if (upEn) begin
      valid_d[upIdx] = 1'b1;
      if (!upMatch && !freeFound) begin
        victim_d = victim_q + IDX_W'(1);
      end
    end
    if (inv_valid_i) begin
      if (inv_all_i) begin
        valid_d  = '0;
        victim_d = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_d[i] &&
              ((upEn && (upIdx == IDX_W'(i))) ? (up_did_i == inv_did_i)
                                              : (tag_q[i] == inv_did_i))) begin
            valid_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // Population count of the current valid bits
  always_comb begin
    occCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occCount = occCount + OCC_W'(valid_q[i]);
    end
  end

  // Control state, response pulses and statistics with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      victim_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      dc_q      <= '0;
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      victim_q  <= victim_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      dc_q      <= dc_d;
      hitCnt_q  <= hitCnt_d;
      missCnt_q <= missCnt_d;
    end
  end

  // Tag and payload storage; not reset, writes suppressed while in reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && upEn) begin
      tag_q[upIdx]  <= up_did_i;
      data_q[upIdx] <= up_dc_i;
    end
  end

  assign lu_hit_o    = hit_q;
  assign lu_miss_o   = miss_q;
  assign lu_dc_o     = dc_q;
  assign occupancy_o = occCount;
  assign hit_cnt_o   = hitCnt_q;
  assign miss_cnt_o  = missCnt_q;

endmodule

// File: tb/tb_iommu_ddtc_multi.sv
// Testbench for iommu_ddtc_multi: directed vector table, hand-written eviction
// and reset sequences, then random traffic checked against a behavioural model.
module tb_iommu_ddtc_multi;

  localparam int DEPTH = 8;
  localparam int DIDW  = 24;
  localparam int DC_W  = 256;

  logic            clk;
  logic            rst;
  logic            luValid;
  logic [DIDW-1:0] luDid;
  logic            luHit;
  logic            luMiss;
  logic [DC_W-1:0] luDc;
  logic            upValid;
  logic [DIDW-1:0] upDid;
  logic [DC_W-1:0] upDc;
  logic            invValid;
  logic            invAll;
  logic [DIDW-1:0] invDid;
  logic [3:0]      occupancy;
  logic [31:0]     hitCnt;
  logic [31:0]     missCnt;

  iommu_ddtc_multi #(.DEPTH(DEPTH), .DEVICE_ID_WIDTH(DIDW), .MSI_TRANSLATION(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .lu_valid_i(luValid), .lu_did_i(luDid),
    .lu_hit_o(luHit), .lu_miss_o(luMiss), .lu_dc_o(luDc),
    .up_valid_i(upValid), .up_did_i(upDid), .up_dc_i(upDc),
    .inv_valid_i(invValid), .inv_all_i(invAll), .inv_did_i(invDid),
    .occupancy_o(occupancy), .hit_cnt_o(hitCnt), .miss_cnt_o(missCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            rst, lu;
    logic [DIDW-1:0] luDid;
    logic            up;
    logic [DIDW-1:0] upDid;
    logic [DC_W-1:0] upDc;
    logic            inv, invAll;
    logic [DIDW-1:0] invDid;
    logic            eHit, eMiss;
    logic [DC_W-1:0] eDc;
    int              eOcc;
    longint          eHc, eMc;
  } vec_t;

  vec_t vecs[$];
  int checkCount = 0;
  int passCount  = 0;

  // Behavioural cache model: per-slot arrays plus round-robin victim
  logic            mValid [DEPTH];
  logic [DIDW-1:0] mDid   [DEPTH];
  logic [DC_W-1:0] mDc    [DEPTH];
  int              mVictim;
  logic            mHit, mMiss;
  logic [DC_W-1:0] mOutDc;
  int              mOcc;
  longint          mHc, mMc;

  logic [DC_W-1:0] p1, p2, pBad;

  function automatic logic [DC_W-1:0] pay(input int d);
    logic [31:0] w;
    w = (32'(d) << 4) | 32'h1;
    return {8{w}};
  endfunction

  function automatic vec_t mk(input string name, input logic r, input logic lu,
      input logic [DIDW-1:0] ld, input logic up, input logic [DIDW-1:0] ud,
      input logic [DC_W-1:0] udc, input logic inv, input logic ia,
      input logic [DIDW-1:0] id, input logic eh, input logic em,
      input logic [DC_W-1:0] edc, input int eo, input longint ehc, input longint emc);
    vec_t v;
    v.name = name; v.rst = r; v.lu = lu; v.luDid = ld; v.up = up; v.upDid = ud;
    v.upDc = udc; v.inv = inv; v.invAll = ia; v.invDid = id; v.eHit = eh;
    v.eMiss = em; v.eDc = edc; v.eOcc = eo; v.eHc = ehc; v.eMc = emc;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    int hitIdx;
    int slot;
    logic kill;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
      mVictim = 0; mHit = 1'b0; mMiss = 1'b0; mOutDc = '0; mHc = 0; mMc = 0; mOcc = 0;
      return;
    end
    hitIdx = -1;
    for (int i = 0; i < DEPTH; i++)
      if (mValid[i] && mDid[i] == luDid) hitIdx = i;
    kill = invValid && (invAll || invDid == luDid);
    mHit = 1'b0; mMiss = 1'b0; mOutDc = '0;
    if (luValid) begin
      if (hitIdx >= 0 && !kill) begin
        mHit = 1'b1; mOutDc = mDc[hitIdx];
        if (mHc < 64'hFFFF_FFFF) mHc++;
      end else begin
        mMiss = 1'b1;
        if (mMc < 64'hFFFF_FFFF) mMc++;
      end
    end
    if (upValid && upDc[0]) begin
      slot = -1;
      for (int i = 0; i < DEPTH; i++)
        if (mValid[i] && mDid[i] == upDid) slot = i;
      if (slot < 0)
        for (int i = DEPTH - 1; i >= 0; i--)
          if (!mValid[i]) slot = i;
      if (slot < 0) begin
        slot = mVictim;
        mVictim = (mVictim + 1) % DEPTH;
      end
      mValid[slot] = 1'b1; mDid[slot] = upDid; mDc[slot] = upDc;
    end
    if (invValid) begin
      if (invAll) begin
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        mVictim = 0;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (mValid[i] && mDid[i] == invDid) mValid[i] = 1'b0;
      end
    end
    mOcc = 0;
    for (int i = 0; i < DEPTH; i++) mOcc += int'(mValid[i]);
  endtask

  task automatic checkField(input string name, input string field,
      input logic [DC_W-1:0] got, input logic [DC_W-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s.%s got %h expected %h", name, field, got, exp);
  endtask

  task automatic checkOutput(input string name, input logic eh, input logic em,
      input logic [DC_W-1:0] edc, input int eo, input longint ehc, input longint emc);
    checkField(name, "hit",  DC_W'(luHit),     DC_W'(eh));
    checkField(name, "miss", DC_W'(luMiss),    DC_W'(em));
    checkField(name, "dc",   luDc,             edc);
    checkField(name, "occ",  DC_W'(occupancy), DC_W'(eo));
    checkField(name, "hcnt", DC_W'(hitCnt),    DC_W'(ehc));
    checkField(name, "mcnt", DC_W'(missCnt),   DC_W'(emc));
  endtask

  // Drive one cycle of inputs, clock it, step the model, settle past the edge
  task automatic drive(input vec_t v);
    rst = v.rst; luValid = v.lu; luDid = v.luDid; upValid = v.up; upDid = v.upDid;
    upDc = v.upDc; invValid = v.inv; invAll = v.invAll; invDid = v.invDid;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v);
    checkOutput(v.name, v.eHit, v.eMiss, v.eDc, v.eOcc, v.eHc, v.eMc);
  endtask

  function automatic vec_t lookup(input int d);
    return mk("lu", 0, 1, DIDW'(d), 0, 0, '0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
  endfunction

  function automatic vec_t fill(input int d);
    return mk("up", 0, 0, 0, 1, DIDW'(d), pay(d), 0, 0, 0, 0, 0, '0, 0, 0, 0);
  endfunction

  initial begin
    vec_t v;
    p1   = {8{32'hA5A5_0001}};
    p2   = {8{32'h5A5A_0003}};
    pBad = {8{32'hFFFF_FFFE}};
    rst = 1'b1; luValid = 0; luDid = 0; upValid = 0; upDid = 0; upDc = '0;
    invValid = 0; invAll = 0; invDid = 0;
    for (int i = 0; i < DEPTH; i++) begin mValid[i] = 0; mDid[i] = 0; mDc[i] = '0; end
    mVictim = 0; mHc = 0; mMc = 0; mOcc = 0; mHit = 0; mMiss = 0; mOutDc = '0;
    @(posedge clk); #1;

    // name rst lu luDid up upDid upDc inv all invDid | hit miss dc occ hc mc
    vecs.push_back(mk("reset",     1, 1, 24'h12, 0, 0,      '0,   0, 0, 0,      0, 0, '0, 0, 0, 0));
    vecs.push_back(mk("coldMiss",  0, 1, 24'h12, 0, 0,      '0,   0, 0, 0,      0, 1, '0, 0, 0, 1));
    vecs.push_back(mk("fill12",    0, 0, 0,      1, 24'h12, p1,   0, 0, 0,      0, 0, '0, 1, 0, 1));
    vecs.push_back(mk("hit12",     0, 1, 24'h12, 0, 0,      '0,   0, 0, 0,      1, 0, p1, 1, 1, 1));
    vecs.push_back(mk("fill33",    0, 0, 0,      1, 24'h33, p1,   0, 0, 0,      0, 0, '0, 2, 1, 1));
    vecs.push_back(mk("fillBad5",  0, 0, 0,      1, 24'h05, pBad, 0, 0, 0,      0, 0, '0, 2, 1, 1));
    vecs.push_back(mk("miss5",     0, 1, 24'h05, 0, 0,      '0,   0, 0, 0,      0, 1, '0, 2, 1, 2));
    vecs.push_back(mk("luInv12",   0, 1, 24'h12, 0, 0,      '0,   1, 0, 24'h12, 0, 1, '0, 1, 1, 3));
    vecs.push_back(mk("refill33",  0, 0, 0,      1, 24'h33, p2,   0, 0, 0,      0, 0, '0, 1, 1, 3));
    vecs.push_back(mk("hit33p2",   0, 1, 24'h33, 0, 0,      '0,   0, 0, 0,      1, 0, p2, 1, 2, 3));
    vecs.push_back(mk("invAll",    0, 0, 0,      0, 0,      '0,   1, 1, 0,      0, 0, '0, 0, 2, 3));
    vecs.push_back(mk("miss33",    0, 1, 24'h33, 0, 0,      '0,   0, 0, 0,      0, 1, '0, 0, 2, 4));
    vecs.push_back(mk("upInv44",   0, 0, 0,      1, 24'h44, p1,   1, 0, 24'h44, 0, 0, '0, 0, 2, 4));
    vecs.push_back(mk("luUp44",    0, 1, 24'h44, 1, 24'h44, p2,   0, 0, 0,      0, 1, '0, 1, 2, 5));
    vecs.push_back(mk("hit44",     0, 1, 24'h44, 0, 0,      '0,   0, 0, 0,      1, 0, p2, 1, 3, 5));
    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Full-cache round-robin replacement
    drive(mk("clr", 0, 0, 0, 0, 0, '0, 1, 1, 0, 0, 0, '0, 0, 0, 0));
    for (int d = 1; d <= 9; d++) drive(fill(d));
    checkOutput("fullOcc", 0, 0, '0, 8, mHc, mMc);
    drive(lookup(1));  checkOutput("evicted1", 0, 1, '0, 8, mHc, mMc);
    drive(lookup(9));  checkOutput("hit9", 1, 0, pay(9), 8, mHc, mMc);
    drive(fill(10));
    drive(lookup(2));  checkOutput("evicted2", 0, 1, '0, 8, mHc, mMc);
    drive(lookup(10)); checkOutput("hitA", 1, 0, pay(10), 8, mHc, mMc);
    drive(lookup(3));  checkOutput("hit3", 1, 0, pay(3), 8, mHc, mMc);

    // Reset asserted while a hitting lookup is presented
    drive(mk("up12", 0, 0, 0, 1, 24'h12, p1, 0, 0, 0, 0, 0, '0, 0, 0, 0));
    v = lookup(24'h12); v.rst = 1'b1;
    drive(v);          checkOutput("rstLookup", 0, 0, '0, 0, 0, 0);
    drive(lookup(24'h12)); checkOutput("postRst", 0, 1, '0, 0, 0, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      v = mk("rnd", 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
      v.rst    = ($urandom_range(0, 59) == 0);
      v.lu     = $urandom_range(0, 1);
      v.luDid  = DIDW'($urandom_range(0, 11));
      v.up     = ($urandom_range(0, 2) != 0);
      v.upDid  = DIDW'($urandom_range(0, 11));
      for (int w = 0; w < DC_W / 32; w++) v.upDc[w*32 +: 32] = $urandom;
      v.upDc[0] = ($urandom_range(0, 4) != 0);
      v.inv    = ($urandom_range(0, 5) == 0);
      v.invAll = ($urandom_range(0, 7) == 0);
      v.invDid = DIDW'($urandom_range(0, 11));
      drive(v);
      checkOutput("rnd", mHit, mMiss, mOutDc, mOcc, mHc, mMc);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/iommu_ddtc_multi.md
IOMMU_DDTC_MULTI -- requirements
Module: iommu_ddtc_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of cache entries, power of two, 2..64.
REQ-002 SHALL have parameter DEVICE_ID_WIDTH, default 24: device_id width.
REQ-003 SHALL have parameter MSI_TRANSLATION, default 0: 0 = base-format DC (DC_W=256), 1 = extended-format DC (DC_W=512).
REQ-004 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1: synchronous, active-high reset.
REQ-006 SHALL have port lu_valid_i  input  1: lookup request.
REQ-007 SHALL have port lu_did_i  input  DEVICE_ID_WIDTH: lookup device_id.
REQ-008 SHALL have port lu_hit_o  output  1: registered lookup hit pulse.
REQ-009 SHALL have port lu_miss_o  output  1: registered lookup miss pulse.
REQ-010 SHALL have port lu_dc_o  output  DC_W: cached DC on hit, all-zero otherwise.
REQ-011 SHALL have port up_valid_i  input  1: fill/update request.
REQ-012 SHALL have port up_did_i  input  DEVICE_ID_WIDTH: fill device_id.
REQ-013 SHALL have port up_dc_i  input  DC_W: fill DC payload, tc in bits [63:0].
REQ-014 SHALL have port inv_valid_i  input  1: invalidation request.
REQ-015 SHALL have port inv_all_i  input  1: qualifies inv_valid_i; 1 = invalidate all entries.
REQ-016 SHALL have port inv_did_i  input  DEVICE_ID_WIDTH: device_id to invalidate when inv_all_i=0.
REQ-017 SHALL have port occupancy_o  output  $clog2(DEPTH)+1: count of valid entries.
REQ-018 SHALL have ports hit_cnt_o, miss_cnt_o  output  32 each: saturating lookup statistics.

Function
REQ-019 Each entry SHALL hold valid bit, device_id tag, DC_W payload; at most one valid entry per device_id at all times.
REQ-020 Lookup SHALL compare lu_did_i against all valid entries; result on lu_hit_o/lu_miss_o/lu_dc_o exactly 1 cycle after lu_valid_i.
REQ-021 lu_hit_o and lu_miss_o SHALL be one-cycle pulses, never both 1, both 0 in cycles following no request.
REQ-022 Update with up_dc_i[0] (tc.v) = 0 SHALL be discarded: no state change.
REQ-023 Update of device_id already cached SHALL overwrite that entry in place; occupancy and victim pointer unchanged.
REQ-024 Update of new device_id, cache not full, SHALL write lowest-index invalid entry.
REQ-025 Update of new device_id, cache full, SHALL replace entry at victim pointer, then victim pointer increments, wrapping DEPTH-1 -> 0; pointer changes only on full-cache replacement.
REQ-026 Invalidation with inv_all_i=1 SHALL clear all valid bits in one cycle; victim pointer reset to 0.
REQ-027 Invalidation with inv_all_i=0 SHALL clear the matching entry's valid bit; no match = no-op.
REQ-028 Same-cycle update and invalidation SHALL apply update first, then invalidation (same did or inv_all -> entry ends invalid).
REQ-029 Lookup SHALL see pre-edge state, except a same-cycle matching invalidation (same did or inv_all) SHALL force a miss; a same-cycle update SHALL not be visible (miss if not previously cached).
REQ-030 hit_cnt_o/miss_cnt_o SHALL increment by 1 with each lu_hit_o/lu_miss_o pulse, saturating at 32'hFFFF_FFFF.
REQ-031 occupancy_o SHALL reflect post-edge valid count, range 0..DEPTH.

Reset
REQ-032 rst_i=1 SHALL clear all valid bits, victim pointer, lu_hit_o, lu_miss_o, lu_dc_o, occupancy_o, hit_cnt_o, miss_cnt_o to 0; payload and tag storage need not reset.
REQ-033 Requests presented while rst_i=1 SHALL be ignored: no response pulse in the following cycle, no state change.

Verification
REQ-034 Reset, lookup did 0x12 -> next cycle lu_miss_o=1, lu_dc_o=0, miss_cnt_o=1, occupancy_o=0.
REQ-035 Fill did 0x12, payload P with tc.v=1, then lookup 0x12 -> lu_hit_o=1, lu_dc_o=P, occupancy_o=1, hit_cnt_o=1.
REQ-036 DEPTH=8: fill dids 0x1..0x9 -> occupancy_o=8; lookup 0x1 -> miss (evicted from entry 0), lookup 0x9 -> hit; fill 0xA evicts 0x2.
REQ-037 Fill did 0x5 with tc.v=0 -> lookup 0x5 misses, occupancy_o unchanged.
REQ-038 Lookup 0x12 same cycle as inv_did 0x12 -> lu_miss_o=1; then inv_all_i=1 -> occupancy_o=0; refill existing did with P2 -> lookup returns P2, occupancy unchanged.
REQ-039 Assert rst_i during lu_valid_i=1 with cache holding 0x12 -> no lu_hit_o next cycle, all counters 0, subsequent lookup 0x12 misses.
